// File: rtl/wb_write_scheduler_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package wb_write_scheduler_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } wb_sched_state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } late_entry_t;

    // x0 is hardwired; writes to it are consumed but never issued
    function automatic logic is_wr_addr(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/wb_write_scheduler_if.sv
// Write-back / long-latency unit / register-file port bundle for the scheduler.
interface wb_write_scheduler_if;
    import wb_write_scheduler_pkg::*;

    logic                  pipe_wr_valid;
    logic [REG_ADDR_W-1:0] pipe_rd_addr;
    logic [REG_DATA_W-1:0] pipe_wr_data;
    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd_addr;
    logic [REG_DATA_W-1:0] lu_wr_data;
    logic                  lu_ready;
    logic                  pipe_stall;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [REG_DATA_W-1:0] rf_wr_data;

    modport master (
        output pipe_wr_valid, pipe_rd_addr, pipe_wr_data,
        output lu_valid, lu_rd_addr, lu_wr_data,
        input  lu_ready, pipe_stall,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  pipe_wr_valid, pipe_rd_addr, pipe_wr_data,
        input  lu_valid, lu_rd_addr, lu_wr_data,
        output lu_ready, pipe_stall,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/wb_late_fifo.sv
// Register FIFO of late results; a pipe write kills every entry (stored or
// incoming) whose destination matches, leaving the slot occupied but invalid.
module wb_late_fifo
    import wb_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  late_entry_t                   push_entry,
    input  logic                          pop,
    input  logic                          kill_en,
    input  logic [REG_ADDR_W-1:0]         kill_rd,
    output late_entry_t                   head,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    late_entry_t             entries [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    push_killed;

    assign head        = entries[rd_ptr];
    assign push_killed = kill_en && (push_entry.rd == kill_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (kill_en && (entries[i].rd == kill_rd)) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (push) begin
                entries[wr_ptr] <= '{valid: push_entry.valid && !push_killed,
                                     rd:    push_entry.rd,
                                     data:  push_entry.data};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/wb_write_scheduler.sv
// Arbitrates the register-file write port between write-back (priority) and
// buffered late results. Optional same-cycle late bypass: WB_WRITE_BYPASS_EN.
module wb_write_scheduler
    import wb_write_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_scheduler_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    wb_sched_state_t         state;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [WAIT_W-1:0]       wait_next;
    logic                    stall_q;

    late_entry_t             head;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        count_next;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    kill_en;
    logic                    lu_ready;
    logic                    bypass;
    logic                    force_go;

    logic                    sel_valid;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic [REG_DATA_W-1:0]   sel_data;

`ifdef WB_WRITE_BYPASS_EN
    assign bypass = bus.lu_valid && (fifo_count == '0) && !bus.pipe_wr_valid
                    && (state != FORCE);
`else
    assign bypass = 1'b0;
`endif

    // A same-cycle pop deliberately does not free a slot for this cycle's push
    assign lu_ready  = (fifo_count < CNT_W'(DEPTH));
    assign fifo_push = bus.lu_valid && lu_ready && is_wr_addr(bus.lu_rd_addr) && !bypass;

    // Write-port select: forced drain, then write-back, then opportunistic drain
    always_comb begin
        fifo_pop  = 1'b0;
        kill_en   = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (state == FORCE) begin
            fifo_pop  = (fifo_count != '0);
            sel_valid = head.valid;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end else if (bus.pipe_wr_valid) begin
            kill_en   = is_wr_addr(bus.pipe_rd_addr);
            sel_valid = 1'b1;
            sel_rd    = bus.pipe_rd_addr;
            sel_data  = bus.pipe_wr_data;
        end else if (fifo_count != '0) begin
            fifo_pop  = 1'b1;
            sel_valid = head.valid;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = bus.lu_rd_addr;
            sel_data  = bus.lu_wr_data;
        end
    end

    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    // Age of the oldest un-drained entry; only counts while something is waiting
    always_comb begin
        wait_next = wait_cnt;
        if (fifo_pop || (count_next == '0)) begin
            wait_next = '0;
        end else if ((fifo_count != '0) && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    assign force_go = (count_next == CNT_W'(DEPTH))
                   || ((count_next != '0) && (wait_next == WAIT_W'(MAX_WAIT)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            stall_q  <= force_go;
            if (force_go) begin
                state <= FORCE;
            end else if (count_next != '0) begin
                state <= PEND;
            end else begin
                state <= IDLE;
            end
        end
    end

    wb_late_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_entry ('{valid: 1'b1, rd: bus.lu_rd_addr, data: bus.lu_wr_data}),
        .pop        (fifo_pop),
        .kill_en    (kill_en),
        .kill_rd    (bus.pipe_rd_addr),
        .head       (head),
        .count      (fifo_count)
    );

    assign bus.lu_ready   = lu_ready;
    assign bus.pipe_stall = stall_q;
    assign bus.rf_wr_en   = !reset && sel_valid && is_wr_addr(sel_rd);
    assign bus.rf_wr_addr = sel_rd;
    assign bus.rf_wr_data = sel_data;

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed + random bench for wb_write_scheduler against a queue-based model.
module tb_wb_write_scheduler;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
`ifdef WB_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ment_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_write_scheduler_if bus ();

    wb_write_scheduler #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ment_t q[$];
    int    w;
    bit    f;

    logic        obs_en, obs_stall, obs_ready;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data;
    logic [31:0] rf_obs [32];

    // Register file as seen through the DUT's write port
    always @(posedge clk) begin
        if (bus.rf_wr_en) rf_obs[bus.rf_wr_addr] <= bus.rf_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        w = 0;
        f = 1'b0;
    endtask

    // One clock: drive, check against model, clock, advance model
    task automatic cyc(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit          e_en, pop, kill, byp, push;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        int          sz0;
        bus.pipe_wr_valid = pv;
        bus.pipe_rd_addr  = prd;
        bus.pipe_wr_data  = pd;
        bus.lu_valid      = lv;
        bus.lu_rd_addr    = lrd;
        bus.lu_wr_data    = ld;
        #2;
        sz0 = q.size();
        pop = 0; kill = 0; byp = 0; e_en = 0; e_rd = '0; e_d = '0;
        if (f) begin
            pop = 1; e_en = q[0].v && (q[0].rd != 0); e_rd = q[0].rd; e_d = q[0].d;
        end else if (pv) begin
            kill = (prd != 0); e_en = (prd != 0); e_rd = prd; e_d = pd;
        end else if (sz0 > 0) begin
            pop = 1; e_en = q[0].v && (q[0].rd != 0); e_rd = q[0].rd; e_d = q[0].d;
        end else if (BYP && lv) begin
            byp = 1; e_en = (lrd != 0); e_rd = lrd; e_d = ld;
        end
        push = lv && (sz0 < DEPTH) && (lrd != 0) && !byp;

        obs_en    = bus.rf_wr_en;
        obs_stall = bus.pipe_stall;
        obs_ready = bus.lu_ready;
        obs_addr  = bus.rf_wr_addr;
        obs_data  = bus.rf_wr_data;
        chk("pipe_stall", 32'(obs_stall), 32'(f));
        chk("lu_ready", 32'(obs_ready), 32'(sz0 < DEPTH));
        chk("rf_wr_en", 32'(obs_en), 32'(e_en));
        if (e_en) begin
            chk("rf_wr_addr", 32'(obs_addr), 32'(e_rd));
            chk("rf_wr_data", obs_data, e_d);
        end

        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (kill) foreach (q[i]) if (q[i].rd == prd) q[i].v = 1'b0;
        if (push) q.push_back('{v: !(kill && lrd == prd), rd: lrd, d: ld});
        if (pop || q.size() == 0) w = 0;
        else if (sz0 > 0 && w < MAX_WAIT) w++;
        f = (q.size() == DEPTH) || (q.size() > 0 && w == MAX_WAIT);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          hold, pv, lv;
        logic [4:0]  prd, lrd;
        logic [31:0] pd, ld;
        int          guard;

        reset = 1'b1;
        bus.pipe_wr_valid = 1'b0; bus.pipe_rd_addr = '0; bus.pipe_wr_data = '0;
        bus.lu_valid = 1'b0; bus.lu_rd_addr = '0; bus.lu_wr_data = '0;
        model_reset();
        #3;
        chk("rst_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst_ready", 32'(bus.lu_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1: single late result with an idle pipe
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA0001);
        chk("t1_first_en", 32'(obs_en), 32'(BYP));
        idle();
        chk("t1_second_en", 32'(obs_en), 32'(!BYP));
        if (!BYP) begin
            chk("t1_addr", 32'(obs_addr), 32'd5);
            chk("t1_data", obs_data, 32'hAAAA0001);
        end
        idle();

        // T2: fill the FIFO under continuous write-back
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'(1 + i), 32'h1000 + 32'(i), 1'b1, 5'(10 + i), 32'hB000 + 32'(i));
        cyc(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0);
        chk("t2_stall", 32'(obs_stall), 32'd1);
        chk("t2_ready", 32'(obs_ready), 32'd0);
        chk("t2_head_addr", 32'(obs_addr), 32'd10);
        cyc(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0);
        chk("t2_restall", 32'(obs_stall), 32'd0);
        chk("t2_pipe_addr", 32'(obs_addr), 32'd20);
        for (int i = 0; i < 3; i++) idle();
        chk("t2_last_addr", 32'(obs_addr), 32'd13);
        idle();

        // T3: one aging entry forces a drain after MAX_WAIT cycles
        cyc(1'b1, 5'd2, 32'h3, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < MAX_WAIT; i++) begin
            cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
            chk("t3_no_stall", 32'(obs_stall), 32'd0);
        end
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk("t3_stall", 32'(obs_stall), 32'd1);
        chk("t3_drain_addr", 32'(obs_addr), 32'd9);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        chk("t3_after", 32'(obs_stall), 32'd0);
        idle();

        // T4: WAW kill of a buffered entry
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h11);
        cyc(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        idle();
        chk("t4_killed_pop", 32'(obs_en), 32'd0);
        chk("t4_r7", rf_obs[7], 32'h22);

        // T5: x0 from both sources
        cyc(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        chk("t5_en", 32'(obs_en), 32'd0);
        idle();
        chk("t5_en_next", 32'(obs_en), 32'd0);
        chk("t5_ready", 32'(obs_ready), 32'd1);

        // T6: reset in the middle of a forced drain with three entries
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd1, 32'h7, 1'b1, 5'(14 + i), 32'hC000 + 32'(i));
        guard = 0;
        while (!f && guard < 12) begin
            cyc(1'b1, 5'd1, 32'h7, 1'b0, 5'd0, 32'd0);
            guard++;
        end
        chk("t6_force_reached", 32'(f), 32'd1);
        bus.pipe_wr_valid = 1'b1; bus.pipe_rd_addr = 5'd1; bus.lu_valid = 1'b0;
        #2;
        chk("t6_pre_stall", 32'(bus.pipe_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_stall", 32'(bus.pipe_stall), 32'd0);
        chk("t6_en", 32'(bus.rf_wr_en), 32'd0);
        chk("t6_ready", 32'(bus.lu_ready), 32'd1);
        bus.pipe_wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t6_no_old", 32'(obs_en), 32'd0);
        end

        // Random traffic; a stalled write-back result is re-presented
        pv = 0; prd = '0; pd = '0;
        for (int n = 0; n < 400; n++) begin
            hold = f;
            if (!hold) begin
                pv  = ($urandom_range(0, 99) < 55);
                prd = 5'($urandom_range(0, 7));
                pd  = $urandom;
            end
            lv  = ($urandom_range(0, 99) < 50);
            lrd = 5'($urandom_range(0, 7));
            ld  = $urandom;
            cyc(pv, prd, pd, lv, lrd, ld);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
        chk("final_empty_ready", 32'(obs_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
